// File: rtl/clk_div_ctrl.sv
// Run/stop and rate controller for the system clock divider.
// New divisors take effect only on a period boundary, so out_clk has no runt pulses.
module clk_div_ctrl #(
  parameter int unsigned CNT_W   = 33,
  parameter int unsigned DEF_DIV = 10000,
  parameter int unsigned MIN_DIV = 2
) (
  input  logic             in_clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             out_clk,
  output logic             tick,
  output logic [CNT_W-1:0] cur_div,
  output logic             running,
  output logic             err
);

  typedef enum logic [1:0] {
    S_STOP,
    S_RUN,
    S_SWITCH
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_cur_div;
  logic [CNT_W-1:0] r_pend;
  logic             r_out;
  logic             r_tick;
  logic             r_err;

  logic             w_tc;
  logic             w_xfer;
  logic             w_bad;
  logic             w_good;
  logic [CNT_W-1:0] w_half;

  assign div_ready = (r_state != S_SWITCH);
  assign running   = (r_state != S_STOP);
  assign out_clk   = r_out;
  assign tick      = r_tick;
  assign err       = r_err;
  assign cur_div   = r_cur_div;

  assign w_tc   = (r_count == r_cur_div - CNT_W'(1));
  assign w_half = r_cur_div >> 1;
  assign w_xfer = div_valid & div_ready;
  assign w_bad  = w_xfer & (div_in < CNT_W'(MIN_DIV));
  assign w_good = w_xfer & ~w_bad;

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_STOP;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_STOP: begin
        if (en) w_next = S_RUN;
      end
      S_RUN: begin
        if (w_tc)        w_next = en ? S_RUN : S_STOP;
        else if (w_good) w_next = S_SWITCH;
      end
      S_SWITCH: begin
        if (w_tc) w_next = en ? S_RUN : S_STOP;
      end
      default: w_next = S_STOP;
    endcase
  end

  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_cur_div <= CNT_W'(DEF_DIV);
      r_pend    <= '0;
      r_out     <= 1'b0;
      r_tick    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_bad;
      if (r_state == S_STOP) begin
        r_count <= '0;
        r_out   <= 1'b0;
        r_tick  <= 1'b0;
        if (w_good) r_cur_div <= div_in;
      end else begin
        r_count <= w_tc ? '0 : r_count + CNT_W'(1);
        r_out   <= (r_count < w_half);
        r_tick  <= w_tc;
        // a divisor arriving mid-period is parked until the boundary
        if (w_tc) begin
          if (r_state == S_SWITCH) r_cur_div <= r_pend;
          else if (w_good)         r_cur_div <= div_in;
        end else if (w_good) begin
          r_pend <= div_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed scenarios plus random traffic
// compared each cycle against a period-position reference model.
module tb_clk_div_ctrl;

  localparam int W   = 33;
  localparam int DEF = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [W-1:0] div_in;
  logic         div_valid;
  logic         div_ready;
  logic         out_clk;
  logic         tick;
  logic [W-1:0] cur_div;
  logic         running;
  logic         err;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: period length, position in period, parked divisor
  int m_div;
  int m_pd;
  int m_pos;
  bit m_run;
  bit m_pend;
  bit e_clk;
  bit e_tick;
  bit e_err;

  clk_div_ctrl #(
    .CNT_W  (W),
    .DEF_DIV(DEF),
    .MIN_DIV(2)
  ) u_dut (
    .in_clk   (clk),
    .rst_n    (rst_n),
    .en       (en),
    .div_in   (div_in),
    .div_valid(div_valid),
    .div_ready(div_ready),
    .out_clk  (out_clk),
    .tick     (tick),
    .cur_div  (cur_div),
    .running  (running),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_div  = DEF;
    m_pd   = 0;
    m_pos  = 0;
    m_run  = 0;
    m_pend = 0;
    e_clk  = 0;
    e_tick = 0;
    e_err  = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_run"}, running, 0);
    chk({tag, "_clk"}, out_clk, 0);
    chk({tag, "_tick"}, tick, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rdy"}, div_ready, 1);
    chk({tag, "_div"}, cur_div, DEF);
  endtask

  task automatic cyc(input bit e, input bit v, input int d);
    bit good;
    bit tc;
    @(negedge clk);
    en        = e;
    div_valid = v;
    div_in    = W'(d);
    chk("rdy_pre", div_ready, !m_pend);
    good  = v && !m_pend && d >= 2;
    e_err = v && !m_pend && d < 2;
    if (!m_run) begin
      e_clk  = 0;
      e_tick = 0;
      m_pos  = 0;
      if (good) m_div = d;
      if (e) m_run = 1;
    end else begin
      tc     = (m_pos == m_div - 1);
      e_clk  = (m_pos < m_div / 2);
      e_tick = tc;
      if (tc) begin
        if (m_pend) begin
          m_div  = m_pd;
          m_pend = 0;
        end else if (good) begin
          m_div = d;
        end
        m_pos = 0;
        if (!e) m_run = 0;
      end else begin
        m_pos++;
        if (good) begin
          m_pend = 1;
          m_pd   = d;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("out_clk", out_clk, e_clk);
    chk("tick", tick, e_tick);
    chk("err", err, e_err);
    chk("running", running, m_run);
    chk("cur_div", cur_div, m_div);
    chk("rdy", div_ready, !m_pend);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    en        = 1'b0;
    div_valid = 1'b0;
    #1;
    m_reset();
    chk_reset_vals("rst_async");
    @(posedge clk);
    #1;
    chk_reset_vals("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic until_pos(input int p);
    for (int k = 0; k < 40 && !(m_run && m_pos == p); k++)
      cyc(1, 0, 0);
  endtask

  task automatic until_stop();
    for (int k = 0; k < 40 && m_run; k++) cyc(0, 0, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    div_valid = 1'b0;
    div_in    = '0;
    m_reset();
    #12;
    chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;

    // default divisor, free running
    repeat (12) cyc(1, 0, 0);
    // load 6 while stopped, then run
    until_stop();
    cyc(0, 1, 6);
    repeat (14) cyc(1, 0, 0);
    // back to 4, then request 10 mid-period
    until_stop();
    cyc(0, 1, 4);
    cyc(1, 0, 0);
    until_pos(1);
    cyc(1, 1, 10);
    repeat (3) cyc(1, 1, 3);
    repeat (22) cyc(1, 0, 0);
    // illegal divisors
    cyc(1, 1, 1);
    cyc(1, 1, 0);
    repeat (3) cyc(1, 0, 0);
    // stop request at start of period
    until_stop();
    cyc(0, 1, 4);
    cyc(1, 0, 0);
    until_pos(0);
    repeat (8) cyc(0, 0, 0);
    // reset while a divisor is parked
    cyc(1, 0, 0);
    until_pos(1);
    cyc(1, 1, 9);
    do_reset();
    repeat (6) cyc(1, 0, 0);
    // odd divisor, change exactly at boundary
    until_stop();
    cyc(0, 1, 5);
    cyc(1, 0, 0);
    until_pos(4);
    cyc(1, 1, 7);
    repeat (16) cyc(1, 0, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      int d;
      bit v;
      bit e;
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        d = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1))
                                        : int'($urandom_range(2, 12));
        v = ($urandom_range(0, 7) == 0);
        e = ($urandom_range(0, 7) != 0);
        cyc(e, v, d);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
